// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bus: pipeline stage fields in, stall/flush/forward controls out.
// Purely wires; no latency or backpressure of its own.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic              ResultSrcE, PCSrcE, MulDivStartE;
    logic              MemReqM, DMemReadyM, CntClr;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushM, FlushW;
    logic              MduBusy, MduDone, MduHold;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MulDivStartE, MemReqM, DMemReadyM, CntClr,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, MduBusy, MduDone, MduHold, StallCount
    );

    modport slave (
        input  Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MulDivStartE, MemReqM, DMemReadyM, CntClr,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushM, FlushW, MduBusy, MduDone, MduHold, StallCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit with MUL/DIV occupancy FSM, dmem wait stalls and stall counter.
// Stall/flush/forward are same-cycle combinational; memory wait outranks MDU, MDU outranks load-use.
module hazard_unit_mc #(
    parameter int REG_AW      = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_unit_mc_if.slave hu
);
    localparam logic [REG_AW-1:0] X0       = '0;
    localparam logic [3:0]        CNT_INIT = 4'(MDU_LATENCY - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {IDLE, MDU_RUN} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             mdu_busy, mdu_done;
    logic [CNT_W-1:0] stall_count;

    logic mem_stall, lw_stall, mdu_stall;

    assign mem_stall = hu.MemReqM & ~hu.DMemReadyM;
    assign lw_stall  = hu.ResultSrcE & ((hu.Rs1E == hu.RdE) | (hu.Rs2E == hu.RdE)) & (hu.RdE != X0);
    assign mdu_stall = ((state == IDLE) & hu.MulDivStartE) | ((state == MDU_RUN) & ~mdu_done);

    // MEM result beats WB result for the same register; x0 is never forwarded.
    always_comb begin
        hu.ForwardAE = 2'b00;
        if (hu.RegWriteM && hu.RdM != X0 && hu.Rs1E == hu.RdM)
            hu.ForwardAE = 2'b10;
        else if (hu.RegWriteW && hu.RdW != X0 && hu.Rs1E == hu.RdW)
            hu.ForwardAE = 2'b01;
        hu.ForwardBE = 2'b00;
        if (hu.RegWriteM && hu.RdM != X0 && hu.Rs2E == hu.RdM)
            hu.ForwardBE = 2'b10;
        else if (hu.RegWriteW && hu.RdW != X0 && hu.Rs2E == hu.RdW)
            hu.ForwardBE = 2'b01;
    end

    always_comb begin
        hu.StallF = 1'b0;
        hu.StallD = 1'b0;
        hu.StallE = 1'b0;
        hu.StallM = 1'b0;
        hu.FlushD = 1'b0;
        hu.FlushE = 1'b0;
        hu.FlushM = 1'b0;
        hu.FlushW = 1'b0;
        if (mem_stall) begin
            // Branch and load-use flushes wait until the memory access completes.
            hu.StallF = 1'b1;
            hu.StallD = 1'b1;
            hu.StallE = 1'b1;
            hu.StallM = 1'b1;
            hu.FlushW = 1'b1;
        end else if (mdu_stall) begin
            hu.StallF = 1'b1;
            hu.StallD = 1'b1;
            hu.StallE = 1'b1;
            hu.FlushM = 1'b1;
        end else begin
            hu.StallF = lw_stall;
            hu.StallD = lw_stall;
            hu.FlushD = hu.PCSrcE;
            hu.FlushE = lw_stall | hu.PCSrcE;
        end
    end

    // mdu_done tracks "in MDU_RUN with cnt==0" as a registered flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mdu_busy <= 1'b0;
            mdu_done <= 1'b0;
        end else if (!mem_stall) begin
            case (state)
                IDLE: begin
                    if (hu.MulDivStartE) begin
                        state    <= MDU_RUN;
                        cnt      <= CNT_INIT;
                        mdu_busy <= 1'b1;
                        mdu_done <= (CNT_INIT == 4'd0);
                    end
                end
                MDU_RUN: begin
                    if (mdu_done) begin
                        state    <= IDLE;
                        mdu_busy <= 1'b0;
                        mdu_done <= 1'b0;
                    end else begin
                        cnt      <= cnt - 4'd1;
                        mdu_done <= (cnt == 4'd1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    mdu_busy <= 1'b0;
                    mdu_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (hu.CntClr)
            stall_count <= '0;
        else if (hu.StallF && stall_count != CNT_MAX)
            stall_count <= stall_count + 1'b1;
    end

    assign hu.MduBusy    = mdu_busy;
    assign hu.MduDone    = mdu_done;
    assign hu.MduHold    = mem_stall;
    assign hu.StallCount = stall_count;
endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(4)) bus ();

    hazard_unit_mc #(.REG_AW(5), .MDU_LATENCY(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hu    (bus.slave)
    );

    wire [3:0] stalls  = {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
    wire [3:0] flushes = {bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Rs1E = '0; bus.Rs2E = '0; bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.ResultSrcE = 1'b0;
        bus.PCSrcE = 1'b0; bus.MulDivStartE = 1'b0; bus.MemReqM = 1'b0;
        bus.DMemReadyM = 1'b0; bus.CntClr = 1'b0;
    endtask

    task automatic clear_count();
        bus.CntClr = 1'b1;
        tick();
        bus.CntClr = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({stalls, flushes, bus.ForwardAE, bus.ForwardBE} !== 12'h000) begin
            n_err++; $display("FAIL reset_ctrl: got %h expected 000", {stalls, flushes, bus.ForwardAE, bus.ForwardBE});
        end
        n_cmp++;
        if ({bus.MduBusy, bus.MduDone, bus.MduHold, bus.StallCount} !== 7'h00) begin
            n_err++; $display("FAIL reset_mdu_cnt: got %h expected 00", {bus.MduBusy, bus.MduDone, bus.MduHold, bus.StallCount});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        bus.Rs1E = 5'd5; bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
        #1;
        n_cmp++;
        if (bus.ForwardAE !== 2'b10) begin
            n_err++; $display("FAIL fwd_mem_prio: got %b expected 10", bus.ForwardAE);
        end
        bus.RdM = 5'd0;
        #1;
        n_cmp++;
        if (bus.ForwardAE !== 2'b01) begin
            n_err++; $display("FAIL fwd_wb: got %b expected 01", bus.ForwardAE);
        end
        bus.Rs2E = 5'd0; bus.RdW = 5'd0;
        #1;
        n_cmp++;
        if (bus.ForwardBE !== 2'b00) begin
            n_err++; $display("FAIL fwd_x0: got %b expected 00", bus.ForwardBE);
        end
        bus.Rs2E = 5'd9; bus.RdM = 5'd9; bus.RegWriteM = 1'b0; bus.RdW = 5'd9; bus.RegWriteW = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0001) begin
            n_err++; $display("FAIL fwd_b_wb_only: got %b expected 0001", {bus.ForwardAE, bus.ForwardBE});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_count();
        bus.ResultSrcE = 1'b1; bus.RdE = 5'd7; bus.Rs2E = 5'd7;
        #1;
        n_cmp++;
        if ({stalls, flushes} !== 8'b1100_0100) begin
            n_err++; $display("FAIL lw_stall: got %b expected 11000100", {stalls, flushes});
        end
        tick();
        bus.RdE = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
        #1;
        n_cmp++;
        if ({stalls, flushes} !== 8'h00) begin
            n_err++; $display("FAIL lw_x0: got %b expected 00000000", {stalls, flushes});
        end
        n_cmp++;
        if (bus.StallCount !== 4'd1) begin
            n_err++; $display("FAIL lw_count: got %0d expected 1", bus.StallCount);
        end
        clear_inputs();
    endtask

    task automatic test_mdu();
        clear_count();
        bus.MulDivStartE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({stalls, flushes, bus.MduBusy, bus.MduDone} !==
                {(k < 3) ? 4'b1110 : 4'b0000, (k < 3) ? 4'b0010 : 4'b0000, k >= 1, k == 3}) begin
                n_err++; $display("FAIL mdu_cycle%0d: got %b busy=%b done=%b", k, {stalls, flushes}, bus.MduBusy, bus.MduDone);
            end
            tick();
        end
        bus.MulDivStartE = 1'b0;
        #1;
        n_cmp++;
        if ({bus.MduBusy, bus.StallCount} !== 5'b0_0011) begin
            n_err++; $display("FAIL mdu_end: got busy=%b count=%0d expected busy=0 count=3", bus.MduBusy, bus.StallCount);
        end
    endtask

    task automatic test_mdu_mem_wait();
        clear_count();
        bus.MulDivStartE = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.MemReqM = (k == 1 || k == 2);
            bus.DMemReadyM = 1'b0;
            #1;
            n_cmp++;
            if ({stalls, flushes, bus.MduBusy, bus.MduDone, bus.MduHold} !==
                {(k == 1 || k == 2) ? 8'b1111_0001 : (k < 5) ? 8'b1110_0010 : 8'b0000_0000,
                 k >= 1, k == 5, (k == 1 || k == 2)}) begin
                n_err++; $display("FAIL mdu_wait_cycle%0d: got %b busy=%b done=%b hold=%b", k, {stalls, flushes}, bus.MduBusy, bus.MduDone, bus.MduHold);
            end
            tick();
        end
        bus.MulDivStartE = 1'b0;
        bus.MemReqM = 1'b0;
        #1;
        n_cmp++;
        if ({bus.MduBusy, bus.StallCount} !== 5'b0_0101) begin
            n_err++; $display("FAIL mdu_wait_end: got busy=%b count=%0d expected busy=0 count=5", bus.MduBusy, bus.StallCount);
        end
    endtask

    task automatic test_branch_under_stall();
        clear_inputs();
        bus.PCSrcE = 1'b1; bus.MemReqM = 1'b1; bus.DMemReadyM = 1'b0;
        #1;
        n_cmp++;
        if ({stalls, flushes} !== 8'b1111_0001) begin
            n_err++; $display("FAIL branch_held: got %b expected 11110001", {stalls, flushes});
        end
        tick();
        bus.DMemReadyM = 1'b1;
        #1;
        n_cmp++;
        if ({stalls, flushes} !== 8'b0000_1100) begin
            n_err++; $display("FAIL branch_release: got %b expected 00001100", {stalls, flushes});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturation_and_reset();
        clear_count();
        bus.ResultSrcE = 1'b1; bus.RdE = 5'd3; bus.Rs1E = 5'd3;
        repeat (20) tick();
        n_cmp++;
        if (bus.StallCount !== 4'd15) begin
            n_err++; $display("FAIL count_saturate: got %0d expected 15", bus.StallCount);
        end
        bus.CntClr = 1'b1;
        tick();
        bus.CntClr = 1'b0;
        n_cmp++;
        if (bus.StallCount !== 4'd0) begin
            n_err++; $display("FAIL count_clr_prio: got %0d expected 0", bus.StallCount);
        end
        clear_inputs();
        bus.MulDivStartE = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.MduBusy, bus.StallCount} !== 5'b1_0010) begin
            n_err++; $display("FAIL pre_reset: got busy=%b count=%0d expected busy=1 count=2", bus.MduBusy, bus.StallCount);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.MduBusy, bus.MduDone, bus.StallCount} !== 6'b00_0000) begin
            n_err++; $display("FAIL async_reset: got busy=%b done=%b count=%0d expected 0 0 0", bus.MduBusy, bus.MduDone, bus.StallCount);
        end
        clear_inputs();
        #1;
        n_cmp++;
        if ({stalls, flushes, bus.ForwardAE, bus.ForwardBE} !== 12'h000) begin
            n_err++; $display("FAIL reset_idle_ctrl: got %h expected 000", {stalls, flushes, bus.ForwardAE, bus.ForwardBE});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_mdu_mem_wait();
        test_branch_under_stall();
        test_saturation_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised successor to the pipeline's hazard/forwarding unit for the 5-stage RISC-V core. It keeps EX-stage operand forwarding, load-use stalls and branch flushes. It adds three things:
- a multi-cycle MUL/DIV occupancy FSM that holds EX for a configurable latency;
- data-memory wait-state stalls driven by a ready handshake;
- a saturating stall-cycle performance counter.

Sits beside the pipeline registers and drives every stall/flush enable.

Parameters:
REG_AW, 5, register-address width (32 architectural registers at default).
MDU_LATENCY, 4, cycles a MUL/DIV instruction occupies EX; legal range 2..16.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
Rs1E, Rs2E  input  REG_AW  source registers in EX.
RdE, RdM, RdW  input  REG_AW  destination registers in EX/MEM/WB.
RegWriteM, RegWriteW  input  1  register write enables in MEM/WB.
ResultSrcE  input  1  EX instruction is a load.
PCSrcE  input  1  branch/jump taken in EX.
MulDivStartE  input  1  EX holds a multi-cycle MUL/DIV instruction.
MemReqM  input  1  MEM holds a load/store accessing data memory.
DMemReadyM  input  1  data memory completes the access this cycle.
CntClr  input  1  synchronous clear of StallCount.
ForwardAE, ForwardBE  output  2  ALU operand select: 00 register file, 10 MEM, 01 WB.
StallF, StallD, StallE, StallM  output  1  hold the PC / IF-ID / ID-EX / EX-MEM registers.
FlushD, FlushE, FlushM, FlushW  output  1  bubble the IF-ID / ID-EX / EX-MEM / MEM-WB registers.
MduBusy  output  1  FSM in MDU_RUN.
MduDone  output  1  final EX cycle of a MUL/DIV; result valid.
MduHold  output  1  MDU datapath must freeze (equals memStall).
StallCount  output  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Forwarding (combinational, per operand):
  - 10 if Rs==RdM, RegWriteM=1 and RdM!=0;
  - else 01 if Rs==RdW, RegWriteW=1 and RdW!=0;
  - else 00.
  - MEM has priority over WB.
- Internal terms:
  - memStall = MemReqM & ~DMemReadyM.
  - lwStall = ResultSrcE & (Rs1E==RdE | Rs2E==RdE) & RdE!=0.
  - mduStall = (state==IDLE & MulDivStartE) | (state==MDU_RUN & cnt!=0).
- Priority: memStall > mduStall > lwStall.
- memStall=1:
  - StallF=StallD=StallE=StallM=1 and FlushW=1.
  - FlushD=FlushE=FlushM=0; a pending PCSrcE or lwStall takes effect only after memStall drops.
  - FSM state and cnt hold; MduHold=1.
- Else mduStall=1: StallF=StallD=StallE=1, FlushM=1.
- Else lwStall=1: StallF=StallD=1, FlushE=1.
- When memStall=0:
  - FlushD = PCSrcE & ~mduStall.
  - FlushE = (lwStall & ~mduStall) | (PCSrcE & ~mduStall).
- FSM states: IDLE, MDU_RUN.
  - IDLE with MulDivStartE=1 and memStall=0: cnt <= MDU_LATENCY-2, go to MDU_RUN.
  - MDU_RUN, cnt!=0, memStall=0: cnt decrements.
  - MDU_RUN, cnt==0: MduDone=1 and no MDU stall that cycle; next state is IDLE.
  - Because the done cycle is in MDU_RUN, the still-asserted MulDivStartE of the same instruction does not retrigger.
  - Net effect: a MUL/DIV occupies EX for exactly MDU_LATENCY cycles, with MDU_LATENCY-1 stall cycles.
- StallCount:
  - CntClr=1: clears to 0, taking priority over increment.
  - Otherwise increments on each cycle with StallF=1 and saturates at all-ones (no wrap).
- Reset (async, rst_n=0, any time including mid-MUL/DIV): state=IDLE, cnt=0, StallCount=0, MduBusy=MduDone=0.
  - Combinational outputs then depend only on the stage inputs; with all inputs 0, every stall, flush and forward output is 0.
- Register x0 never forwards or causes a load-use stall.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE=1, RdE=7, Rs2E=7 -> StallF=StallD=FlushE=1 for one cycle; StallCount +1.
- MUL/DIV, MDU_LATENCY=4: MulDivStartE held from cycle t -> StallF/D/E=1 and FlushM=1 for cycles t..t+2; MduDone=1 and no stall at t+3; MduBusy=1 for t+1..t+3; StallCount +3.
- Memory wait during MUL/DIV: DMemReadyM=0 with MemReqM=1 for 2 cycles at t+1 -> all four stalls and FlushW=1 for those cycles; cnt frozen; MduDone at t+5.
- Branch under stall: PCSrcE=1 while memStall=1 -> FlushD=FlushE=0. On the cycle memStall drops -> FlushD=FlushE=1.
- Saturation and reset: CNT_W=4 with 20 stall cycles -> StallCount=15. Asserting rst_n=0 mid-MDU_RUN -> MduBusy=0 and StallCount=0 immediately, without a clock edge.
